// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and access-size helper for the dmem_hs data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Number of bytes touched by an access; 0 marks the illegal encoding.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational access checker and big-endian load formatter for dmem_hs.
// mem_bytes carries the bytes at addr, addr+1, addr+2, addr+3 from MSB to LSB.
module dmem_lane_fmt
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 256
) (
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] mem_bytes,
    output logic        err,
    output logic [31:0] ld_data
);

    logic [2:0]  nbytes;
    logic [32:0] last_addr;
    logic        bad_size;
    logic        misaligned;
    logic        out_of_range;

    // Range check uses a 33-bit sum so an access near 0xFFFFFFFF cannot wrap into range.
    always_comb begin
        nbytes       = size_bytes(size);
        bad_size     = (size == SZ_ILLEGAL);
        misaligned   = ((size == SZ_HALF) && addr[0]) ||
                       ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        last_addr    = {1'b0, addr} + {30'd0, nbytes} - 33'd1;
        out_of_range = !bad_size && (last_addr >= 33'(DEPTH_BYTES));
        err          = bad_size || misaligned || out_of_range;
    end

    always_comb begin
        ld_data = 32'd0;
        if (!err) begin
            case (size)
                SZ_BYTE: ld_data = {{24{!is_unsigned && mem_bytes[31]}}, mem_bytes[31:24]};
                SZ_HALF: ld_data = {{16{!is_unsigned && mem_bytes[31]}}, mem_bytes[31:16]};
                default: ld_data = mem_bytes;
            endcase
        end
    end

endmodule

// File: rtl/dmem_hs.sv
// Byte-addressed big-endian data memory with valid/ready handshake and configurable latency.
// Optional macro DMEM_STATS_EN adds saturating load/store/error counters.
module dmem_hs
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] stat_rd,
    output logic [31:0] stat_wr,
    output logic [31:0] stat_err
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH_BYTES);
    localparam logic [3:0]  LAT_LAST = 4'(READ_LAT - 1);

    logic [7:0]    mem [DEPTH_BYTES];

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          accept;
    logic          wr_en;
    logic          fmt_err;
    logic [31:0]   fmt_data;
    logic [31:0]   mem_bytes;
    logic [AW-1:0] a0, a1, a2, a3;

    // Lane addresses may wrap inside the array; that only happens for accesses already flagged.
    assign a0        = req_addr[AW-1:0];
    assign a1        = a0 + AW'(1);
    assign a2        = a0 + AW'(2);
    assign a3        = a0 + AW'(3);
    assign mem_bytes = {mem[a0], mem[a1], mem[a2], mem[a3]};

    dmem_lane_fmt #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_lane_fmt (
        .size       (req_size),
        .is_unsigned(req_unsigned),
        .addr       (req_addr),
        .mem_bytes  (mem_bytes),
        .err        (fmt_err),
        .ld_data    (fmt_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    accept  = 1'b1;
                    rdata_d = (req_we || fmt_err) ? 32'd0 : fmt_data;
                    err_d   = fmt_err;
                    if (READ_LAT > 1) begin
                        state_d = WAIT;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign wr_en = accept && req_we && !fmt_err;

    // Storage is deliberately not reset; a store commits on its accept edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (req_size)
                SZ_BYTE: begin
                    mem[a0] <= req_wdata[7:0];
                end
                SZ_HALF: begin
                    mem[a0] <= req_wdata[15:8];
                    mem[a1] <= req_wdata[7:0];
                end
                default: begin
                    mem[a0] <= req_wdata[31:24];
                    mem[a1] <= req_wdata[23:16];
                    mem[a2] <= req_wdata[15:8];
                    mem[a3] <= req_wdata[7:0];
                end
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid && err_q;

`ifdef DMEM_STATS_EN
    logic [31:0] stat_rd_q, stat_rd_d;
    logic [31:0] stat_wr_q, stat_wr_d;
    logic [31:0] stat_err_q, stat_err_d;

    always_comb begin
        stat_rd_d  = stat_rd_q;
        stat_wr_d  = stat_wr_q;
        stat_err_d = stat_err_q;
        if (accept) begin
            if (fmt_err) begin
                stat_err_d = (stat_err_q == 32'hFFFF_FFFF) ? stat_err_q : stat_err_q + 32'd1;
            end else if (req_we) begin
                stat_wr_d = (stat_wr_q == 32'hFFFF_FFFF) ? stat_wr_q : stat_wr_q + 32'd1;
            end else begin
                stat_rd_d = (stat_rd_q == 32'hFFFF_FFFF) ? stat_rd_q : stat_rd_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_q  <= 32'd0;
            stat_wr_q  <= 32'd0;
            stat_err_q <= 32'd0;
        end else begin
            stat_rd_q  <= stat_rd_d;
            stat_wr_q  <= stat_wr_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_rd  = stat_rd_q;
    assign stat_wr  = stat_wr_q;
    assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench for dmem_hs: two instances (latency 1 and 4) against a byte-array reference model.
module tb_dmem_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][1:0]  req_size;
    logic [1:0]       req_unsigned;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       rsp_err;
`ifdef DMEM_STATS_EN
    logic [1:0][31:0] stat_rd;
    logic [1:0][31:0] stat_wr;
    logic [1:0][31:0] stat_err;
`endif

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] modelMem [2][256];
    int         modelRd  [2];
    int         modelWr  [2];
    int         modelErr [2];
    int         latency  [2] = '{1, 4};

    dmem_hs #(.DEPTH_BYTES(256), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
`ifdef DMEM_STATS_EN
        , .stat_rd(stat_rd[0]), .stat_wr(stat_wr[0]), .stat_err(stat_err[0])
`endif
    );

    dmem_hs #(.DEPTH_BYTES(256), .READ_LAT(4)) u_lat4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
`ifdef DMEM_STATS_EN
        , .stat_rd(stat_rd[1]), .stat_wr(stat_wr[1]), .stat_err(stat_err[1])
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: applies the access rules directly to a byte array.
    task automatic modelAccess(input int d, input bit we, input logic [1:0] sz, input bit uns,
                               input logic [31:0] addr, input logic [31:0] wd,
                               output logic [31:0] expData, output bit expErr);
        int n;
        longint lastAddr;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        if (n == 0) begin
            expErr = 1'b1;
        end else begin
            lastAddr = longint'(addr) + longint'(n) - 1;
            expErr   = ((addr % n) != 0) || (lastAddr >= 256);
        end
        expData = 32'd0;
        if (!expErr) begin
            if (we) begin
                for (int k = 0; k < n; k++)
                    modelMem[d][int'(addr) + k] = 8'(wd >> (8 * (n - 1 - k)));
            end else begin
                v = 32'd0;
                for (int k = 0; k < n; k++)
                    v = (v << 8) | 32'(modelMem[d][int'(addr) + k]);
                if (!uns && n < 4 && v[8 * n - 1])
                    v = v | (32'hFFFF_FFFF << (8 * n));
                expData = v;
            end
        end
        if (expErr) modelErr[d]++;
        else if (we) modelWr[d]++;
        else modelRd[d]++;
    endtask

    // One full transaction on instance d, called at a negedge; hold = extra cycles rsp_ready stays low.
    task automatic applyStimulus(input int d, input bit we, input logic [1:0] sz, input bit uns,
                                 input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic [31:0] expData;
        bit          expErr;
        logic [31:0] heldData;
        logic        heldErr;
        int          n;
        bit          bad;
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_size[d]     = sz;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wd;
        rsp_ready[d]    = 1'b0;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checkOutput("req_ready_timeout", 32'd0, 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        modelAccess(d, we, sz, uns, addr, wd, expData, expErr);
        @(negedge clk);
        // Busy-period inputs are junk the DUT must ignore.
        req_valid[d]    = 1'($urandom);
        req_we[d]       = 1'($urandom);
        req_size[d]     = 2'($urandom);
        req_unsigned[d] = 1'($urandom);
        req_addr[d]     = $urandom_range(0, 255);
        req_wdata[d]    = $urandom;
        n   = 1;
        bad = 1'b0;
        while (rsp_valid[d] !== 1'b1 && n < 20) begin
            if (req_ready[d] !== 1'b0) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        checkOutput("latency", 32'(n), 32'(latency[d]));
        heldData = rsp_rdata[d];
        heldErr  = rsp_err[d];
        for (int h = 0; h < hold; h++) begin
            if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b1) bad = 1'b1;
            @(negedge clk);
            if (rsp_rdata[d] !== heldData || rsp_err[d] !== heldErr) bad = 1'b1;
        end
        if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b1) bad = 1'b1;
        checkOutput("busy_ready_stable", 32'(bad), 32'd0);
        checkOutput("rdata", rsp_rdata[d], expData);
        checkOutput("err", 32'(rsp_err[d]), 32'(expErr));
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        checkOutput("idle_after_hs", 32'({rsp_valid[d], req_ready[d]}), 32'b01);
        req_valid[d] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] expData;
        bit          expErr;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_we       = '0;
        req_size     = '0;
        req_unsigned = '0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = '0;
        for (int d = 0; d < 2; d++) begin
            modelRd[d] = 0; modelWr[d] = 0; modelErr[d] = 0;
        end
        repeat (2) @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_rdata0", rsp_rdata[0], 32'd0);
        checkOutput("reset_rdata1", rsp_rdata[1], 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(req_ready), 32'b11);

        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 256; a += 4)
                applyStimulus(d, 1'b1, 2'b10, 1'b0, 32'(a), $urandom, 0);

        applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 0);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1);
        applyStimulus(0, 1'b1, 2'b00, 1'b0, 32'h20, 32'hFFFF_FF80, 0);
        applyStimulus(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00F0, 0);
        applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 2);

        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 0);
        applyStimulus(0, 1'b1, 2'b01, 1'b0, 32'hFF, 32'h0000_ABCD, 0);
        applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'hFF, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 0);
        applyStimulus(0, 1'b1, 2'b11, 1'b0, 32'h30, 32'hDEAD_BEEF, 0);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 0);

        applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h5566_7788, 0);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3);
        applyStimulus(1, 1'b0, 2'b01, 1'b0, 32'hFE, 32'h0, 1);

        for (int i = 0; i < 160; i++) begin
            addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 259));
            applyStimulus(i % 2, 1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom,
                          $urandom_range(0, 3));
        end

        // Reset while instance 1 is waiting on a committed store.
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_size[1]  = 2'b10;
        req_addr[1]  = 32'h40;
        req_wdata[1] = 32'hCAFE_F00D;
        checkOutput("ready_before_store40", 32'(req_ready[1]), 32'd1);
        modelAccess(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, expData, expErr);
        @(negedge clk);
        req_valid[1] = 1'b0;
        checkOutput("in_wait_ready", 32'({rsp_valid[1], req_ready[1]}), 32'b00);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            modelRd[d] = 0; modelWr[d] = 0; modelErr[d] = 0;
        end
        @(negedge clk);
        checkOutput("idle_after_mid_reset", 32'(req_ready), 32'b11);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);

        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);
        applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 0);
        applyStimulus(0, 1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_1234, 0);
        applyStimulus(0, 1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 0);
        applyStimulus(0, 1'b1, 2'b00, 1'b0, 32'h44, 32'h0000_0099, 0);
        applyStimulus(0, 1'b0, 2'b01, 1'b0, 32'h43, 32'h0, 0);
`ifdef DMEM_STATS_EN
        for (int d = 0; d < 2; d++) begin
            checkOutput("stat_rd", stat_rd[d], 32'(modelRd[d]));
            checkOutput("stat_wr", stat_wr[d], 32'(modelWr[d]));
            checkOutput("stat_err", stat_err[d], 32'(modelErr[d]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
